axi_stream_to_bt656: RTL

AXI_STREAM_TO_BT656 -- requirements
Module: axi_stream_to_bt656

---
 rtl/bt656_pkg.sv | 39 +++
 rtl/bt656_hdr_gen.sv | 31 +++
 rtl/axi_stream_to_bt656.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/bt656_pkg.sv
// -----------------------------------------------------------------------------
// bt656_pkg
// Shared definitions for the AXI-Stream to BT.656 formatter:
//   - bt656_state_e : line-timing FSM states
//   - HDR_*_BIT     : bit positions of F, V and H inside the EAV/SAV XY byte
//   - BLANK_CB/Y    : blanking code words (chroma 0x80, luma 0x10)
//   - clip_data()   : keeps 0x00/0xFF out of the payload (reserved for sync)
// -----------------------------------------------------------------------------
package bt656_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EAV,
      ST_HBLANK,
      ST_SAV,
      ST_ACTIVE
   } bt656_state_e;

   localparam int HDR_F_BIT = 6;
   localparam int HDR_V_BIT = 5;
   localparam int HDR_H_BIT = 4;

   localparam logic [7:0] BLANK_CB  = 8'h80;
   localparam logic [7:0] BLANK_Y   = 8'h10;
   localparam logic [7:0] HDR_PRE_FF = 8'hFF;
   localparam logic [7:0] HDR_PRE_00 = 8'h00;

   // 0x00 and 0xFF only ever appear inside timing reference codes.
   function automatic logic [7:0] clip_data(input logic [7:0] d);
      logic [7:0] r;
      case (d)
         8'h00:   r = 8'h01;
         8'hFF:   r = 8'hFE;
         default: r = d;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/bt656_hdr_gen.sv
// -----------------------------------------------------------------------------
// bt656_hdr_gen
// Combinational builder of the fourth EAV/SAV byte (XY) with its protection
// bits: XY = {1, F, V, H, V^H, F^H, F^V, F^V^H}.
// Ports:
//   f_i  : field bit (0 = first field)
//   v_i  : vertical blanking bit (1 on blank lines)
//   h_i  : 1 for EAV, 0 for SAV
//   xy_o : resulting header byte
// -----------------------------------------------------------------------------
module bt656_hdr_gen
   import bt656_pkg::*;
(
   input  logic       f_i,
   input  logic       v_i,
   input  logic       h_i,
   output logic [7:0] xy_o
);

   always_comb begin
      xy_o            = 8'h80;
      xy_o[HDR_F_BIT] = f_i;
      xy_o[HDR_V_BIT] = v_i;
      xy_o[HDR_H_BIT] = h_i;
      xy_o[3]         = v_i ^ h_i;
      xy_o[2]         = f_i ^ h_i;
      xy_o[1]         = f_i ^ v_i;
      xy_o[0]         = f_i ^ v_i ^ h_i;
   end

endmodule

// File: rtl/axi_stream_to_bt656.sv
// -----------------------------------------------------------------------------
// axi_stream_to_bt656
// Free-running BT.656 timing generator that fills the active region of active
// lines with bytes pulled from an AXI-Stream 4:2:2 source (Cb Y Cr Y).
// Each line: EAV(4) + H_BLANK blank bytes + SAV(4) + 2*H_ACTIVE active bytes.
// Each field: V_BLANK blank lines then V_ACTIVE active lines; frame = F0, F1.
// Ports:
//   axi_clk_i, axi_rstn_i : byte clock, asynchronous active-low reset
//   tx_enable_i           : start/keep transmitting (stop honoured at frame end)
//   err_clr_i             : clears the sticky flags
//   s_t*                  : AXI-Stream byte input (tlast = line end, tuser = SOF)
//   bt656_data_o          : registered BT.656 byte stream
//   underrun_o            : sticky, source had no byte for an active slot
//   sync_err_o            : sticky, tlast/tuser disagree with generator timing
// -----------------------------------------------------------------------------
module axi_stream_to_bt656
   import bt656_pkg::*;
#(
   parameter int H_ACTIVE = 720,
   parameter int H_BLANK  = 268,
   parameter int V_BLANK  = 22,
   parameter int V_ACTIVE = 240
) (
   input  logic       axi_clk_i,
   input  logic       axi_rstn_i,
   input  logic       tx_enable_i,
   input  logic       err_clr_i,
   input  logic [7:0] s_tdata_i,
   input  logic       s_tvalid_i,
   output logic       s_tready_o,
   input  logic       s_tlast_i,
   input  logic       s_tuser_i,
   output logic [7:0] bt656_data_o,
   output logic       underrun_o,
   output logic       sync_err_o
);

   localparam int ACT_BYTES = 2 * H_ACTIVE;
   localparam int LINES     = V_BLANK + V_ACTIVE;
   localparam int CNT_MAX0  = (ACT_BYTES > H_BLANK) ? ACT_BYTES : H_BLANK;
   localparam int CNT_MAX   = (CNT_MAX0 > 4) ? CNT_MAX0 : 4;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);
   localparam int LINE_W    = $clog2(LINES + 1);

   bt656_state_e      state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [LINE_W-1:0] line_q, line_d;
   logic              field_q, field_d;
   logic [7:0]        data_q, data_d;
   logic              underrun_q, sync_err_q;
   logic              underrun_set, sync_set;

   logic              v_blank_line;
   logic              is_eav;
   logic [7:0]        hdr_xy;
   logic [7:0]        hdr_byte;
   logic [7:0]        blank_byte;
   logic              last_pos;
   logic              first_pos;

   assign v_blank_line = (line_q < LINE_W'(V_BLANK));
   assign is_eav       = (state_q == ST_EAV);

   bt656_hdr_gen u_hdr_gen (
      .f_i  (field_q),
      .v_i  (v_blank_line),
      .h_i  (is_eav),
      .xy_o (hdr_xy)
   );

   // Header byte sequence FF 00 00 XY indexed by the shared byte counter.
   always_comb begin
      case (cnt_q[1:0])
         2'd0:    hdr_byte = HDR_PRE_FF;
         2'd3:    hdr_byte = hdr_xy;
         default: hdr_byte = HDR_PRE_00;
      endcase
   end

   // Blank pattern is 0x80,0x10,... from the start of each region; both
   // regions start with the counter at zero, so its LSB selects the word.
   assign blank_byte = cnt_q[0] ? BLANK_Y : BLANK_CB;
   assign last_pos   = (cnt_q == CNT_W'(ACT_BYTES - 1));
   assign first_pos  = (cnt_q == '0) && (line_q == LINE_W'(V_BLANK)) && !field_q;

   // Depends on state registers only, never on s_tvalid_i.
   assign s_tready_o = (state_q == ST_ACTIVE) && !v_blank_line;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q + CNT_W'(1);
      line_d       = line_q;
      field_d      = field_q;
      data_d       = BLANK_Y;
      underrun_set = 1'b0;
      sync_set     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d   = '0;
            line_d  = '0;
            field_d = 1'b0;
            data_d  = BLANK_Y;
            if (tx_enable_i) begin
               state_d = ST_EAV;
            end
         end
         ST_EAV: begin
            data_d = hdr_byte;
            if (cnt_q == CNT_W'(3)) begin
               cnt_d   = '0;
               state_d = ST_HBLANK;
            end
         end
         ST_HBLANK: begin
            data_d = blank_byte;
            if (cnt_q == CNT_W'(H_BLANK - 1)) begin
               cnt_d   = '0;
               state_d = ST_SAV;
            end
         end
         ST_SAV: begin
            data_d = hdr_byte;
            if (cnt_q == CNT_W'(3)) begin
               cnt_d   = '0;
               state_d = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (v_blank_line) begin
               data_d = blank_byte;
            end else if (s_tvalid_i) begin
               data_d = clip_data(s_tdata_i);
               if ((s_tlast_i != last_pos) || (s_tuser_i != first_pos)) begin
                  sync_set = 1'b1;
               end
            end else begin
               data_d       = blank_byte;
               underrun_set = 1'b1;
            end
            // Line/field/frame wrap happens here so the next EAV follows
            // immediately; tx_enable_i is only sampled at the frame end.
            if (last_pos) begin
               cnt_d   = '0;
               state_d = ST_EAV;
               if (line_q == LINE_W'(LINES - 1)) begin
                  line_d = '0;
                  if (field_q) begin
                     field_d = 1'b0;
                     if (!tx_enable_i) begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     field_d = 1'b1;
                  end
               end else begin
                  line_d = line_q + LINE_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
      if (!axi_rstn_i) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         line_q     <= '0;
         field_q    <= 1'b0;
         data_q     <= BLANK_Y;
         underrun_q <= 1'b0;
         sync_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         line_q     <= line_d;
         field_q    <= field_d;
         data_q     <= data_d;
         // A fresh error in the clearing cycle keeps the flag set.
         underrun_q <= underrun_set | (underrun_q & ~err_clr_i);
         sync_err_q <= sync_set | (sync_err_q & ~err_clr_i);
      end
   end

   assign bt656_data_o = data_q;
   assign underrun_o   = underrun_q;
   assign sync_err_o   = sync_err_q;

endmodule
